// File: rtl/matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmul_engine
// Brief    : Sequencer computing C = A x B from row-major matrices in memory.
// Revision : 1.0
// ============================================================================
module matmul_engine #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8,
   parameter int SAT    = 0
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  dim_x,
   input  logic [DIM_W-1:0]  dim_y,
   input  logic [DIM_W-1:0]  dim_z,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [ADDR_W-1:0] base_c,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              res_wr_en,
   output logic [ADDR_W-1:0] res_addr,
   output logic [ACC_W-1:0]  res_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int c_PW = 2 * DIM_W;
   localparam int c_MW = 2 * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_MAC  = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DIM_W-1:0]  r_dim_x, r_dim_y, r_dim_z;
   logic [ADDR_W-1:0] r_base_a, r_base_b, r_base_c;
   logic [DIM_W-1:0]  r_i, r_j, r_k;
   logic [ACC_W-1:0]  r_acc;
   logic [DATA_W-1:0] r_a;
   logic              r_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] r_res_addr;
   logic [ACC_W-1:0]  r_res_data;

   logic              w_zero;
   logic              w_i_last, w_j_last, w_k_last;
   logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_c_addr;
   logic [c_MW-1:0]   w_prod;
   logic [ACC_W:0]    w_sum;
   logic [ACC_W-1:0]  w_acc_next;

   assign w_zero   = (dim_x == '0) || (dim_y == '0) || (dim_z == '0);
   assign w_i_last = (r_i == r_dim_x - DIM_W'(1));
   assign w_j_last = (r_j == r_dim_z - DIM_W'(1));
   assign w_k_last = (r_k == r_dim_y - DIM_W'(1));

   assign w_a_addr = r_base_a + ADDR_W'(c_PW'(r_i) * c_PW'(r_dim_y)) + ADDR_W'(r_k);
   assign w_b_addr = r_base_b + ADDR_W'(c_PW'(r_k) * c_PW'(r_dim_z)) + ADDR_W'(r_j);
   assign w_c_addr = r_base_c + ADDR_W'(c_PW'(r_i) * c_PW'(r_dim_z)) + ADDR_W'(r_j);

   assign w_prod = c_MW'(r_a) * c_MW'(mem_rdata);
   assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'(w_prod);

   // A clamped accumulator re-clamps on every further non-zero product.
   generate
      if (SAT != 0) begin : g_sat
         assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
      end else begin : g_wrap
         assign w_acc_next = w_sum[ACC_W-1:0];
      end
   endgenerate

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_zero ? S_DONE : S_RD_A;
         S_RD_A: w_next = S_RD_B;
         S_RD_B: w_next = S_MAC;
         S_MAC:  w_next = w_k_last ? S_WR : S_RD_A;
         S_WR:   w_next = (w_i_last && w_j_last) ? S_DONE : S_RD_A;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_dim_x    <= '0;
         r_dim_y    <= '0;
         r_dim_z    <= '0;
         r_base_a   <= '0;
         r_base_b   <= '0;
         r_base_c   <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_acc      <= '0;
         r_a        <= '0;
         r_err      <= 1'b0;
         r_mem_addr <= '0;
         r_res_addr <= '0;
         r_res_data <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dim_x  <= dim_x;
                  r_dim_y  <= dim_y;
                  r_dim_z  <= dim_z;
                  r_base_a <= base_a;
                  r_base_b <= base_b;
                  r_base_c <= base_c;
                  r_i      <= '0;
                  r_j      <= '0;
                  r_k      <= '0;
                  r_acc    <= '0;
                  r_err    <= w_zero;
               end
            end
            S_RD_A: r_mem_addr <= w_a_addr;
            S_RD_B: begin
               r_mem_addr <= w_b_addr;
               r_a        <= mem_rdata;
            end
            S_MAC: begin
               r_acc <= w_acc_next;
               if (!w_k_last) r_k <= r_k + DIM_W'(1);
            end
            S_WR: begin
               r_res_addr <= w_c_addr;
               r_res_data <= r_acc;
               r_acc      <= '0;
               r_k        <= '0;
               if (w_j_last) begin
                  r_j <= '0;
                  r_i <= w_i_last ? '0 : r_i + DIM_W'(1);
               end else begin
                  r_j <= r_j + DIM_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Strobed outputs show live values in their state and hold the last one otherwise.
   assign mem_rd_en = (r_state == S_RD_A) || (r_state == S_RD_B);
   assign mem_addr  = (r_state == S_RD_A) ? w_a_addr :
                      (r_state == S_RD_B) ? w_b_addr : r_mem_addr;
   assign res_wr_en = (r_state == S_WR);
   assign res_addr  = (r_state == S_WR) ? w_c_addr : r_res_addr;
   assign res_data  = (r_state == S_WR) ? r_acc : r_res_data;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = r_err;

endmodule
`default_nettype wire
